// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a one-entry valid/ready holding
// register. Bit period is cfg_div_i+1 clocks; start is confirmed at the
// mid-bit point cfg_div_i[11:1] and data/stop bits are sampled one full
// period apart from there.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   rx_en_i      receiver enable (low forces IDLE)
//   cfg_div_i    divider, bit period = cfg_div_i+1 clocks (3..4095)
//   rx_i         asynchronous serial input, idle high
//   rx_data_o    received byte, valid while rx_valid_o=1
//   rx_valid_o   holding register full
//   rx_ready_i   consumer accepts the held byte
//   frame_err_o  1-cycle pulse, stop bit sampled low
//   overrun_o    1-cycle pulse, byte dropped because the register was full
//   busy_o       FSM not in IDLE
module uart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_en_i,
  input  logic [11:0] cfg_div_i,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] div_q, div_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_m_q, rx_s_q, rx_d_q;
  logic        load;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  // Resetting to 1 (idle line) avoids a false start after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= rx_i;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      div_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;

    if (!rx_en_i && state_q != IDLE) begin
      // Abort silently; the holding register is left untouched.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Needs a fresh falling edge, so a held-low break never restarts.
          if (rx_en_i && !rx_s_q && rx_d_q) begin
            state_d = START;
            cnt_d   = '0;
            div_d   = cfg_div_i;
          end
        end
        START: begin
          if (cnt_q == {1'b0, div_q[11:1]}) begin
            cnt_d   = '0;
            bit_d   = '0;
            // Line back high at mid-start means a glitch: drop it quietly.
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        DATA: begin
          if (cnt_q == div_q) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        STOP: begin
          if (cnt_q == div_q) begin
            // Return at mid-stop so the next start edge is caught at once.
            state_d = IDLE;
            cnt_d   = '0;
            if (!rx_s_q)                      ferr_d = 1'b1;
            else if (!valid_q || rx_ready_i) begin
              load    = 1'b1;
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else                          ovr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A same-cycle load wins over the consume so the new byte stays valid.
    if (valid_q && rx_ready_i && !load) valid_d = 1'b0;
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. A negedge monitor logs every load (valid rise
// or data change while valid) with its latency from the start-bit drive.
// Latency = 2 synchronizer clocks + (stop sample + 1) clocks after the edge:
//   div=15: 2 + 153 = 155      div=7: 2 + 1+3+72+1 = 79
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst_i, rx_en_i, rx_i, rx_ready_i;
  logic [11:0] cfg_div_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx dut (
    .clk_i(clk), .rst_i(rst_i), .rx_en_i(rx_en_i), .cfg_div_i(cfg_div_i),
    .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int start_cyc = 0;

  // Monitor: single writer of all logged state.
  int         ev_lat[$];
  logic [7:0] ev_dat[$];
  int         n_ferr = 0, n_ovr = 0, n_busy = 0;
  logic       prev_vld = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  always @(negedge clk) begin
    if (rx_valid_o && (!prev_vld || rx_data_o != prev_dat)) begin
      ev_lat.push_back(cyc - start_cyc);
      ev_dat.push_back(rx_data_o);
    end
    if (frame_err_o) n_ferr++;
    if (overrun_o)   n_ovr++;
    if (busy_o)      n_busy++;
    prev_vld = rx_valid_o;
    prev_dat = rx_data_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-bit frame, each bit div+1 clocks. With rdy_pulse, ready is
  // high only for the cycle of the stop-sample edge (drive index 3+H+9(div+1)).
  task automatic send_frame(input logic [7:0] b, input int div, input logic stop,
                            input logic rdy_pulse);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10*(div+1); i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      rx_i = fr[i/(div+1)];
      if (rdy_pulse) rx_ready_i = (i == 9*(div+1) + 3 + div/2);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [7:0] d, input int lat);
    if (ev_dat.size() > idx) begin
      chk({tag, "_dat"}, ev_dat[idx], d);
      chk({tag, "_lat"}, ev_lat[idx], lat);
    end
  endtask

  int b, fb, ob, bb;

  initial begin
    rst_i = 1'b1; rx_en_i = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b1; cfg_div_i = 12'd15;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data_o, 8'h00);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    // Basic back-to-back frames
    b = ev_dat.size(); fb = n_ferr; ob = n_ovr;
    send_frame(8'h55, 15, 1'b1, 1'b0);
    send_frame(8'hA3, 15, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("basic_n", ev_dat.size() - b, 2);
    chk_ev("basic0", b, 8'h55, 155);
    chk_ev("basic1", b+1, 8'hA3, 155);
    chk("basic_flags", (n_ferr - fb) + (n_ovr - ob), 0);
    chk("basic_cons", rx_valid_o, 0);

    // Glitch: 4 clocks low
    b = ev_dat.size(); bb = n_busy;
    for (int i = 0; i < 4; i++) begin @(negedge clk); rx_i = 1'b0; end
    @(negedge clk); rx_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_seen", (n_busy - bb) > 0, 1);
    chk("glitch_idle", busy_o, 0);
    chk("glitch_noev", ev_dat.size() - b, 0);
    chk("glitch_flags", (n_ferr - fb) + (n_ovr - ob), 0);
    send_frame(8'h3C, 15, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("glitch_n", ev_dat.size() - b, 1);
    chk_ev("glitch_3c", b, 8'h3C, 155);

    // Framing error followed by a 3-bit break
    cfg_div_i = 12'd7;
    b = ev_dat.size(); fb = n_ferr;
    send_frame(8'hF0, 7, 1'b0, 1'b0);
    bb = n_busy;
    repeat (24) @(negedge clk);
    chk("brk_nostart", n_busy - bb, 0);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_pulse", n_ferr - fb, 1);
    chk("ferr_noev", ev_dat.size() - b, 0);
    chk("ferr_valid", rx_valid_o, 0);

    // Overrun, then load with ready in the stop-sample cycle
    rx_ready_i = 1'b0;
    b = ev_dat.size(); ob = n_ovr;
    send_frame(8'h11, 7, 1'b1, 1'b0);
    send_frame(8'h22, 7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("ovr_data", rx_data_o, 8'h11);
    chk("ovr_valid", rx_valid_o, 1);
    chk("ovr_pulse", n_ovr - ob, 1);
    chk("ovr_n", ev_dat.size() - b, 1);
    chk_ev("ovr_11", b, 8'h11, 79);
    send_frame(8'h33, 7, 1'b1, 1'b1);
    rx_ready_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("sim_data", rx_data_o, 8'h33);
    chk("sim_valid", rx_valid_o, 1);
    chk("sim_noovr", n_ovr - ob, 1);
    chk_ev("sim_33", b+1, 8'h33, 79);

    // Reset during data bit 4 with a byte held
    cfg_div_i = 12'd15;
    fork
      send_frame(8'hC3, 15, 1'b1, 1'b0);
      begin
        repeat (88) @(negedge clk);
        chk("mrst_busy_pre", busy_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_valid", rx_valid_o, 0);
        chk("mrst_data", rx_data_o, 8'h00);
        chk("mrst_flags", {frame_err_o, overrun_o}, 0);
      end
    join
    @(negedge clk); rst_i = 1'b0;
    repeat (5) @(negedge clk);

    // Enable dropped mid-frame with 0x5A held
    b = ev_dat.size(); fb = n_ferr; ob = n_ovr;
    send_frame(8'h5A, 15, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("en_held", rx_data_o, 8'h5A);
    fork
      send_frame(8'h00, 15, 1'b1, 1'b0);
      begin
        repeat (56) @(negedge clk);
        chk("en_busy_pre", busy_o, 1);
        rx_en_i = 1'b0;
        @(negedge clk);
        chk("en_idle", busy_o, 0);
        chk("en_valid", rx_valid_o, 1);
        chk("en_data", rx_data_o, 8'h5A);
      end
    join
    repeat (4) @(negedge clk);
    chk("en_flags", (n_ferr - fb) + (n_ovr - ob), 0);
    rx_en_i = 1'b1; rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    b = ev_dat.size();
    send_frame(8'h81, 15, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("en_n", ev_dat.size() - b, 1);
    chk_ev("en_81", b, 8'h81, 155);

    // Divider latched at start; change mid-frame takes effect next frame
    b = ev_dat.size();
    fork
      send_frame(8'h96, 15, 1'b1, 1'b0);
      begin repeat (40) @(negedge clk); cfg_div_i = 12'd7; end
    join
    send_frame(8'h4B, 7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("div_n", ev_dat.size() - b, 2);
    chk_ev("div_96", b, 8'h96, 155);
    chk_ev("div_4b", b+1, 8'h4B, 79);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
